// File: rtl/rotary_setpoint_accel_if.sv
// Load request and setpoint status bundle for rotary_setpoint_accel.
// The master drives setpoint load requests; the slave (the accelerator)
// returns the registered setpoints, window pulse and per-channel flags.
interface rotary_setpoint_accel_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SP_WIDTH = 16
);
    logic                         load_en;
    logic [2:0]                   load_ch;
    logic [SP_WIDTH-1:0]          load_val;
    logic [CHANNELS*SP_WIDTH-1:0] setpoint;
    logic                         update;
    logic [CHANNELS-1:0]          sat;
    logic [CHANNELS-1:0]          qerr;

    modport master (
        output load_en, load_ch, load_val,
        input  setpoint, update, sat, qerr
    );

    modport slave (
        input  load_en, load_ch, load_val,
        output setpoint, update, sat, qerr
    );
endinterface

// File: rtl/rotary_setpoint_accel.sv
// Multi-channel quadrature encoder to setpoint converter with per-window
// acceleration. Detents are counted per channel over a fixed window; at the
// window end each setpoint moves by |count| (linear) or |count|^2 (quadratic),
// saturating at 0 and SP_MAX. A host can overwrite any setpoint at any time.
module rotary_setpoint_accel #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SP_WIDTH = 16,
    parameter int unsigned SP_MAX   = 65535,
    parameter int unsigned WINDOW   = 40000000,
    parameter int unsigned ACCEL    = 1,
    parameter int unsigned MAX_RATE = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] enc_a,
    input  logic [CHANNELS-1:0] enc_b,
    rotary_setpoint_accel_if.slave bus
);

    // Signed window count wide enough for +/-MAX_RATE; step holds its square.
    localparam int unsigned CW = $clog2(MAX_RATE + 1) + 1;
    localparam int unsigned SW = 2 * CW;
    localparam int unsigned XW = SP_WIDTH + SW + 1;

    localparam logic [SP_WIDTH-1:0]  SP_MAX_V = SP_WIDTH'(SP_MAX);
    localparam logic signed [CW-1:0] RATE_POS = CW'(MAX_RATE);
    localparam logic signed [CW-1:0] RATE_NEG = -RATE_POS;
    localparam logic [31:0]          WIN_LAST = 32'(WINDOW - 1);

    // Synchronizer chain: s1/s2 resolve metastability, s3 is the previous
    // sample used for edge detection.
    logic [CHANNELS-1:0] a_s1_q, a_s2_q, a_s3_q;
    logic [CHANNELS-1:0] b_s1_q, b_s2_q, b_s3_q;
    logic [CHANNELS-1:0] a_s1_d, a_s2_d, a_s3_d;
    logic [CHANNELS-1:0] b_s1_d, b_s2_d, b_s3_d;

    logic [31:0] win_cnt_q, win_cnt_d;
    logic        update_q, update_d;
    logic        tick;

    // Shift encoder pins through the synchronizer chain.
    always_comb begin
        a_s1_d = enc_a;
        a_s2_d = a_s1_q;
        a_s3_d = a_s2_q;
        b_s1_d = enc_b;
        b_s2_d = b_s1_q;
        b_s3_d = b_s2_q;
    end

    // Synchronizer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_s1_q <= '0;
            a_s2_q <= '0;
            a_s3_q <= '0;
            b_s1_q <= '0;
            b_s2_q <= '0;
            b_s3_q <= '0;
        end else begin
            a_s1_q <= a_s1_d;
            a_s2_q <= a_s2_d;
            a_s3_q <= a_s3_d;
            b_s1_q <= b_s1_d;
            b_s2_q <= b_s2_d;
            b_s3_q <= b_s3_d;
        end
    end

    // Free-running window counter; tick marks the last cycle of a window.
    always_comb begin
        tick      = (win_cnt_q == WIN_LAST);
        win_cnt_d = tick ? '0 : win_cnt_q + 32'd1;
        update_d  = tick;
    end

    // Window counter and update pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_q <= '0;
            update_q  <= 1'b0;
        end else begin
            win_cnt_q <= win_cnt_d;
            update_q  <= update_d;
        end
    end

    assign bus.update = update_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic                 rise_a;
        logic                 both_chg;
        logic                 cnt_up;
        logic                 cnt_dn;
        logic signed [CW-1:0] base;
        logic signed [CW-1:0] count_q, count_d;
        logic [CW-1:0]        mag;
        logic [SW-1:0]        mag_x;
        logic [SW-1:0]        step;
        logic [XW-1:0]        sum;
        logic [SP_WIDTH-1:0]  setpoint_q, setpoint_d;
        logic                 qerr_q, qerr_d;
        logic                 load_hit;

        // Decode one detent per rising A edge; a simultaneous A/B change is
        // flagged as a quadrature error and never counted.
        always_comb begin
            rise_a   = a_s2_q[g] & ~a_s3_q[g];
            both_chg = (a_s2_q[g] ^ a_s3_q[g]) & (b_s2_q[g] ^ b_s3_q[g]);
            cnt_up   = rise_a & ~both_chg & ~b_s2_q[g];
            cnt_dn   = rise_a & ~both_chg &  b_s2_q[g];
            qerr_d   = qerr_q | both_chg;
            // At tick the count restarts from zero but still absorbs this
            // cycle's detent, so it lands in the next window.
            base     = tick ? '0 : count_q;
            count_d  = base;
            if (cnt_up && (base != RATE_POS)) begin
                count_d = base + CW'(1);
            end else if (cnt_dn && (base != RATE_NEG)) begin
                count_d = base - CW'(1);
            end
        end

        // Apply the accelerated step at tick; a coincident load overrides it.
        always_comb begin
            mag        = count_q[CW-1] ? CW'(-count_q) : CW'(count_q);
            mag_x      = SW'(mag);
            step       = (ACCEL == 1) ? mag_x * mag_x : mag_x;
            sum        = XW'(setpoint_q) + XW'(step);
            load_hit   = bus.load_en && (bus.load_ch == 3'(g));
            setpoint_d = setpoint_q;
            if (tick && (count_q != '0)) begin
                if (!count_q[CW-1]) begin
                    setpoint_d = (sum > XW'(SP_MAX_V)) ? SP_MAX_V : sum[SP_WIDTH-1:0];
                end else if (XW'(step) >= XW'(setpoint_q)) begin
                    setpoint_d = '0;
                end else begin
                    setpoint_d = setpoint_q - SP_WIDTH'(step);
                end
            end
            if (load_hit) begin
                setpoint_d = (bus.load_val > SP_MAX_V) ? SP_MAX_V : bus.load_val;
            end
        end

        // Per-channel count, setpoint and sticky error registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                count_q    <= '0;
                setpoint_q <= '0;
                qerr_q     <= 1'b0;
            end else begin
                count_q    <= count_d;
                setpoint_q <= setpoint_d;
                qerr_q     <= qerr_d;
            end
        end

        assign bus.setpoint[g*SP_WIDTH +: SP_WIDTH] = setpoint_q;
        assign bus.sat[g]  = (setpoint_q == '0) || (setpoint_q == SP_MAX_V);
        assign bus.qerr[g] = qerr_q;
    end

endmodule

// File: tb/tb_rotary_setpoint_accel.sv
// Scoreboard bench for rotary_setpoint_accel: one quadratic and one linear
// instance share clock and reset; expected window results are queued by the
// stimulus and checked by a monitor on every update pulse.
module tb_rotary_setpoint_accel;

    localparam int unsigned WIN = 200;
    localparam int unsigned SPM = 1000;

    typedef struct {
        logic [63:0] sp;
        logic [3:0]  sat;
        logic [3:0]  qerr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] qa, qb, la, lb;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int win_start;

    exp_t exp_q[$];
    exp_t exp_l[$];

    rotary_setpoint_accel_if #(.CHANNELS(4), .SP_WIDTH(16)) ifq ();
    rotary_setpoint_accel_if #(.CHANNELS(4), .SP_WIDTH(16)) ifl ();

    rotary_setpoint_accel #(
        .CHANNELS(4), .SP_WIDTH(16), .SP_MAX(SPM), .WINDOW(WIN),
        .ACCEL(1), .MAX_RATE(24)
    ) dut_q (
        .clk(clk), .rst(rst), .enc_a(qa), .enc_b(qb), .bus(ifq)
    );

    rotary_setpoint_accel #(
        .CHANNELS(4), .SP_WIDTH(16), .SP_MAX(SPM), .WINDOW(WIN),
        .ACCEL(0), .MAX_RATE(24)
    ) dut_l (
        .clk(clk), .rst(rst), .enc_a(la), .enc_b(lb), .bus(ifl)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pack(input int s0, input int s1, input int s2, input int s3);
        return {16'(s3), 16'(s2), 16'(s1), 16'(s0)};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic push(input bit lin, input logic [63:0] sp, input logic [3:0] sat,
                        input logic [3:0] qerr);
        exp_t e;
        e.sp = sp;
        e.sat = sat;
        e.qerr = qerr;
        if (lin) exp_l.push_back(e);
        else     exp_q.push_back(e);
    endtask

    // Monitor: every update pulse consumes one expected window result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ifq.update) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL quad_update: unexpected pulse at cycle %0d, required none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("quad_setpoint", ifq.setpoint, e.sp);
                    check("quad_sat", 64'(ifq.sat), 64'(e.sat));
                    check("quad_qerr", 64'(ifq.qerr), 64'(e.qerr));
                end
            end
            if (ifl.update) begin
                if (exp_l.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL lin_update: unexpected pulse at cycle %0d, required none", cyc);
                end else begin
                    e = exp_l.pop_front();
                    check("lin_setpoint", ifl.setpoint, e.sp);
                    check("lin_sat", 64'(ifl.sat), 64'(e.sat));
                    check("lin_qerr", 64'(ifl.qerr), 64'(e.qerr));
                end
            end
        end
    end

    task automatic set_ab(input bit lin, input logic [3:0] mask, input bit av, input bit bv);
        if (lin) begin
            la = (la & ~mask) | (mask & {4{av}});
            lb = (lb & ~mask) | (mask & {4{bv}});
        end else begin
            qa = (qa & ~mask) | (mask & {4{av}});
            qb = (qb & ~mask) | (mask & {4{bv}});
        end
    endtask

    // n full quadrature cycles on the masked channels; CW raises A with B low.
    task automatic detents(input bit lin, input logic [3:0] mask, input bit cw, input int n);
        logic [1:0] seq [4];
        if (cw) seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        else    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                set_ab(lin, mask, seq[k][1], seq[k][0]);
            end
        end
    endtask

    task automatic do_load(input bit lin, input logic [2:0] ch, input logic [15:0] val);
        @(posedge clk); #1;
        if (lin) begin ifl.load_en = 1'b1; ifl.load_ch = ch; ifl.load_val = val; end
        else     begin ifq.load_en = 1'b1; ifq.load_ch = ch; ifq.load_val = val; end
        @(posedge clk); #1;
        ifl.load_en = 1'b0;
        ifq.load_en = 1'b0;
    endtask

    task automatic wait_update(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * int'(WIN); i++) begin
            @(negedge clk);
            if (ifq.update) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL %s: no update within %0d cycles, required one", tag, 3 * WIN);
        end
        win_start = cyc;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_quad_sp"},   ifq.setpoint, '0);
        check({tag, "_quad_sat"},  64'(ifq.sat), 64'hF);
        check({tag, "_quad_qerr"}, 64'(ifq.qerr), '0);
        check({tag, "_quad_upd"},  64'(ifq.update), '0);
        check({tag, "_lin_sp"},    ifl.setpoint, '0);
        check({tag, "_lin_sat"},   64'(ifl.sat), 64'hF);
        check({tag, "_lin_qerr"},  64'(ifl.qerr), '0);
        check({tag, "_lin_upd"},   64'(ifl.update), '0);
    endtask

    initial begin
        int rel;
        rst = 1'b1;
        qa = '0; qb = '0; la = '0; lb = '0;
        ifq.load_en = 1'b0; ifq.load_ch = '0; ifq.load_val = '0;
        ifl.load_en = 1'b0; ifl.load_ch = '0; ifl.load_val = '0;
        repeat (4) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;

        // Window 1: 3 CW on quad ch0 -> 9; linear ch0 -> 3, linear ch1 loaded 2.
        push(0, pack(9, 0, 0, 0), 4'b1110, 4'b0000);
        push(1, pack(3, 2, 0, 0), 4'b1100, 4'b0000);
        detents(0, 4'b0001, 1'b1, 3);
        detents(1, 4'b0001, 1'b1, 3);
        do_load(1, 3'd1, 16'd2);
        wait_update("w1");

        // Window 2: quad ch1 30 CW clamps at 24 -> 576; ch2 990 + 16 saturates;
        // out-of-range load ignored. Linear ch1 2 - 5 floors at 0; ch3 load clamps.
        push(0, pack(9, 576, SPM, 0), 4'b1100, 4'b0000);
        push(1, pack(3, 0, 0, SPM), 4'b1110, 4'b0000);
        do_load(0, 3'd2, 16'(SPM - 10));
        do_load(0, 3'd5, 16'd77);
        detents(0, 4'b0110, 1'b1, 4);
        detents(0, 4'b0010, 1'b1, 26);
        detents(1, 4'b0010, 1'b0, 5);
        do_load(1, 3'd3, 16'd5000);
        wait_update("w2");

        // Window 3: ch3 counts discarded by a load in the tick cycle, while a
        // detent detected in that same cycle carries over; ch0 A/B glitch.
        push(0, pack(9, 576, SPM, 500), 4'b0100, 4'b0001);
        push(1, pack(3, 0, 0, SPM), 4'b1110, 4'b0000);
        detents(0, 4'b1000, 1'b1, 2);
        @(posedge clk); #1; set_ab(0, 4'b0001, 1'b1, 1'b1);
        @(posedge clk); #1; set_ab(0, 4'b0001, 1'b0, 1'b0);
        do begin @(posedge clk); #1; end while (cyc != win_start + int'(WIN) - 3);
        set_ab(0, 4'b1000, 1'b1, 1'b0);
        do begin @(posedge clk); #1; end while (cyc != win_start + int'(WIN) - 1);
        ifq.load_en = 1'b1; ifq.load_ch = 3'd3; ifq.load_val = 16'd500;
        @(posedge clk); #1;
        ifq.load_en = 1'b0;
        wait_update("w3");

        // Window 4: carried detent gives ch3 +1; linear ch2 net +1.
        push(0, pack(9, 576, SPM, 501), 4'b0100, 4'b0001);
        push(1, pack(3, 0, 1, SPM), 4'b1010, 4'b0000);
        @(posedge clk); #1; set_ab(0, 4'b1000, 1'b1, 1'b1);
        @(posedge clk); #1; set_ab(0, 4'b1000, 1'b0, 1'b1);
        @(posedge clk); #1; set_ab(0, 4'b1000, 1'b0, 1'b0);
        detents(1, 4'b0100, 1'b1, 2);
        detents(1, 4'b0100, 1'b0, 1);
        wait_update("w4");

        // Window 5: pending counts discarded by a mid-window reset.
        detents(0, 4'b0001, 1'b1, 2);
        detents(1, 4'b0001, 1'b1, 2);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("midrst");
        rst = 1'b0;
        rel = cyc;
        push(0, pack(0, 0, 0, 0), 4'b1111, 4'b0000);
        push(1, pack(0, 0, 0, 0), 4'b1111, 4'b0000);
        wait_update("w6");
        check("first_tick_latency", 64'(cyc - rel), 64'(WIN));

        repeat (3) @(posedge clk);
        #1;
        check("quad_queue_drained", 64'(exp_q.size()), '0);
        check("lin_queue_drained", 64'(exp_l.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rotary_setpoint_accel.md
ROTARY_SETPOINT_ACCEL -- requirements
Module: rotary_setpoint_accel

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent quadrature encoder channels (1..8).
REQ-002 Parameter SP_WIDTH, default 16, setpoint width per channel, unsigned.
REQ-003 Parameter SP_MAX, default 65535, upper saturation limit for every setpoint (SP_MAX <= 2^SP_WIDTH-1).
REQ-004 Parameter WINDOW, default 40000000, clk cycles per acceleration window (2..2^32-1).
REQ-005 Parameter ACCEL, default 1, step law: 0 = linear, 1 = quadratic.
REQ-006 Parameter MAX_RATE, default 24, clamp on detents counted per window.
REQ-007 clk  input  1  system clock; all logic on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 enc_a  input  CHANNELS  encoder phase A per channel, asynchronous.
REQ-010 enc_b  input  CHANNELS  encoder phase B per channel, asynchronous.
REQ-011 load_en  input  1  one-cycle request to overwrite one setpoint.
REQ-012 load_ch  input  3  channel index for load; values >= CHANNELS ignored.
REQ-013 load_val  input  SP_WIDTH  value to load; values > SP_MAX load SP_MAX.
REQ-014 setpoint  output  CHANNELS*SP_WIDTH  registered setpoints, channel n at bits [n*SP_WIDTH +: SP_WIDTH].
REQ-015 update  output  1  one-cycle pulse at every window end.
REQ-016 sat  output  CHANNELS  per-channel flag, high while setpoint equals 0 or SP_MAX.
REQ-017 qerr  output  CHANNELS  sticky per-channel flag, illegal quadrature transition seen.

Function
REQ-018 Each enc_a/enc_b bit shall pass through a 2-flop synchronizer; decoding uses a third registered copy (edge detection), so input-to-detect latency is 3 cycles.
REQ-019 Rising edge of synchronized A with synchronized B = 0 shall count +1; with B = 1 shall count -1; all other transitions shall not count.
REQ-020 A and B both changing in the same cycle shall not count and shall set qerr[n]; qerr clears only on rst.
REQ-021 Each channel shall hold a signed window count saturating at +/-MAX_RATE; counts beyond the clamp are discarded.
REQ-022 A free-running window counter shall run 0..WINDOW-1; at WINDOW-1 the window ends (the "tick").
REQ-023 At tick, per channel, magnitude m = |count|; step = m when ACCEL=0, m*m when ACCEL=1; step width SP_WIDTH, no truncation for MAX_RATE <= 255.
REQ-024 At tick, positive count adds step, negative count subtracts step, zero leaves setpoint unchanged.
REQ-025 Addition shall saturate at SP_MAX; subtraction shall saturate at 0; no wrap-around under any count.
REQ-026 Setpoint and update shall change on the clock edge following the tick cycle (1-cycle latency); update high for exactly that one cycle.
REQ-027 Window counts shall clear at tick; a detent detected in the tick cycle itself shall count toward the next window, not be lost.
REQ-028 load_en shall write the addressed setpoint on the next edge; if it coincides with a tick write to the same channel, load wins and that channel's window count is discarded.
REQ-029 load_en with load_ch >= CHANNELS shall have no effect.
REQ-030 sat[n] shall be combinationally derived from the registered setpoint.
REQ-031 Channels shall be fully independent; activity on one shall never alter another's count or setpoint.

Reset
REQ-032 While rst is high: setpoints = 0, window counts = 0, window counter = 0, update = 0, qerr = 0, synchronizer flops = 0; sat = all ones (setpoint at 0).
REQ-033 rst asserted mid-window shall discard all pending counts; first tick after release occurs WINDOW cycles after rst deasserts.
REQ-034 Synchronizer flops = 0 after reset; an encoder held with A = 1 at release shall produce one spurious rising edge, which is accepted behaviour.

Verification
REQ-035 WINDOW=10, ACCEL=1: 3 CW detents on ch0 within one window -> setpoint[0] = 9 one cycle after tick, update pulse, others 0.
REQ-036 ACCEL=0, setpoint[1] loaded 2, then 5 CCW detents -> setpoint[1] = 0, sat[1] = 1, no wrap.
REQ-037 ACCEL=1, load SP_MAX-10 on ch2, 4 CW detents -> setpoint[2] = SP_MAX, sat[2] = 1.
REQ-038 30 CW detents in one window, ACCEL=1, MAX_RATE=24 -> step 576 exactly.
REQ-039 Detent detected in tick cycle on ch3 plus load_en to ch3 same cycle -> ch3 = load_val, the detent appears in next window's step.
REQ-040 A and B toggled in same cycle on ch0 -> no count, qerr[0] = 1 until rst.
